// File: rtl/multiword_adder_ctrl_if.sv
// Bus between an operand source and the multi-word adder controller.
// The master drives the request and operands; the slave (the controller)
// returns busy/done and the registered result.
interface multiword_adder_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
);
    localparam int N = WIDTH * WORDS;

    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         c_out;

    modport master (
        output start, a_in, b_in, c_in,
        input  busy, done, sum, c_out
    );

    modport slave (
        input  start, a_in, b_in, c_in,
        output busy, done, sum, c_out
    );
endinterface

// File: rtl/multiword_adder_ctrl.sv
// Multi-word adder: one WIDTH-bit ripple-carry adder is reused over WORDS
// cycles, least-significant word first, with the inter-word carry held in a
// register. The result and carry-out are registered and held until the next
// operation completes.

module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carry_in,
    output logic [WIDTH-1:0] z,
    output logic             carry_out
);
    logic [WIDTH:0] carryChain;

    assign carryChain[0] = carry_in;

    // Plain full-adder cells chained bit by bit; no '+' operator is used so
    // this stays the only arithmetic resource in the controller.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign z[i]              = x[i] ^ y[i] ^ carryChain[i];
        assign carryChain[i + 1] = (x[i] & y[i]) | (carryChain[i] & (x[i] ^ y[i]));
    end

    assign carry_out = carryChain[WIDTH];
endmodule

module multiword_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input logic                    clk,
    input logic                    rst,
    multiword_adder_ctrl_if.slave  bus
);
    localparam int N    = WIDTH * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [WORDS-1:0][WIDTH-1:0]   a_q, a_d;
    logic [WORDS-1:0][WIDTH-1:0]   b_q, b_d;
    logic [WORDS-1:0][WIDTH-1:0]   acc_q, acc_d;
    logic                          carry_q, carry_d;
    logic [IDXW-1:0]               idx_q, idx_d;
    logic [N-1:0]                  sum_q, sum_d;
    logic                          cout_q, cout_d;

    logic [WIDTH-1:0]              wordSum;
    logic                          wordCarry;

    ripple_carry_adder #(.WIDTH(WIDTH)) u_adder (
        .x         (a_q[idx_q]),
        .y         (b_q[idx_q]),
        .carry_in  (carry_q),
        .z         (wordSum),
        .carry_out (wordCarry)
    );

    // Next-state and datapath updates: accept a request when not running,
    // then fold one word per cycle into the accumulator and publish the
    // merged result on the last word.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    carry_d = bus.c_in;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d[idx_q] = wordSum;
                carry_d      = wordCarry;
                if (idx_q == LAST_IDX) begin
                    sum_d   = acc_d;
                    cout_d  = wordCarry;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any running operation and
    // clears the published result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.c_out = cout_q;
endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// Testbench for multiword_adder_ctrl: directed vector table on a 4-word
// instance, hand-written back-to-back / ignored-start / reset-abort
// sequences, and random operands on both a 4-word and a 1-word instance.
module tb_multiword_adder_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multiword_adder_ctrl_if #(.WIDTH(8), .WORDS(4)) bus4 ();
    multiword_adder_ctrl_if #(.WIDTH(8), .WORDS(1)) bus1 ();

    multiword_adder_ctrl #(.WIDTH(8), .WORDS(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    multiword_adder_ctrl #(.WIDTH(8), .WORDS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] expSum;
        logic        expCout;
    } vec_t;

    vec_t vecs[8];

    int checks   = 0;
    int failures = 0;

    int          lat;
    int          busyCnt;
    int          doneCnt;
    logic        held;
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] exp33;
    logic [7:0]  ra8, rb8;
    logic [8:0]  exp9;
    logic [31:0] sumAtDone;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic c);
        bus4.a_in  = a;
        bus4.b_in  = b;
        bus4.c_in  = c;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
    endtask

    task automatic waitDone(input logic scramble, output int latency, output int busyCycles);
        busyCycles = int'(bus4.busy);
        latency    = 0;
        while (!bus4.done && latency < 20) begin
            if (scramble) begin
                bus4.a_in = $urandom;
                bus4.b_in = $urandom;
                bus4.c_in = ~bus4.c_in;
            end
            tick();
            latency++;
            busyCycles += int'(bus4.busy);
        end
    endtask

    initial begin
        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        vecs[1] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0};
        vecs[2] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        vecs[4] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[6] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};
        vecs[7] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};

        rst        = 1'b1;
        bus4.start = 1'b0;
        bus4.a_in  = '0;
        bus4.b_in  = '0;
        bus4.c_in  = 1'b0;
        bus1.start = 1'b0;
        bus1.a_in  = '0;
        bus1.b_in  = '0;
        bus1.c_in  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        checkOutput("reset_busy", bus4.busy, 0);
        checkOutput("reset_done", bus4.done, 0);
        checkOutput("reset_sum", bus4.sum, 0);
        checkOutput("reset_cout", bus4.c_out, 0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin);
            waitDone(1'b1, lat, busyCnt);
            checkOutput($sformatf("vec%0d_sum", i), bus4.sum, vecs[i].expSum);
            checkOutput($sformatf("vec%0d_cout", i), bus4.c_out, vecs[i].expCout);
            checkOutput($sformatf("vec%0d_latency", i), lat, 4);
            checkOutput($sformatf("vec%0d_busycycles", i), busyCnt, 4);
            tick();
            checkOutput($sformatf("vec%0d_donefall", i), bus4.done, 0);
            checkOutput($sformatf("vec%0d_idlebusy", i), bus4.busy, 0);
        end

        bus4.a_in  = 32'h000000FF;
        bus4.b_in  = 32'h00000001;
        bus4.c_in  = 1'b0;
        bus4.start = 1'b1;
        tick();
        lat = 0;
        while (!bus4.done && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput("b2b_first_latency", lat, 4);
        checkOutput("b2b_first_sum", bus4.sum, 32'h00000100);
        checkOutput("b2b_first_cout", bus4.c_out, 0);
        bus4.a_in = 32'h80000000;
        bus4.b_in = 32'h80000000;
        tick();
        bus4.start = 1'b0;
        lat  = 1;
        held = 1'b1;
        while (!bus4.done && lat < 20) begin
            if (bus4.sum !== 32'h00000100) held = 1'b0;
            tick();
            lat++;
        end
        checkOutput("b2b_second_gap", lat, 5);
        checkOutput("b2b_first_held", held, 1);
        checkOutput("b2b_second_sum", bus4.sum, 32'h00000000);
        checkOutput("b2b_second_cout", bus4.c_out, 1);
        tick();
        checkOutput("b2b_donefall", bus4.done, 0);

        bus4.a_in  = 32'h00000001;
        bus4.b_in  = 32'h00000002;
        bus4.c_in  = 1'b0;
        bus4.start = 1'b1;
        tick();
        doneCnt   = 0;
        held      = 1'b1;
        sumAtDone = 32'hDEADBEEF;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (bus4.done) begin
                doneCnt++;
                sumAtDone  = bus4.sum;
                bus4.start = 1'b0;
            end else if (doneCnt == 0 && bus4.sum !== 32'h00000000) begin
                held = 1'b0;
            end
            tick();
        end
        checkOutput("ignored_start_donecount", doneCnt, 1);
        checkOutput("ignored_start_held", held, 1);
        checkOutput("ignored_start_sum", sumAtDone, 32'h00000003);
        checkOutput("ignored_start_idle", bus4.busy, 0);

        applyStimulus(32'h0000FFFF, 32'h00000001, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_busy", bus4.busy, 0);
        checkOutput("abort_done", bus4.done, 0);
        checkOutput("abort_sum", bus4.sum, 0);
        checkOutput("abort_cout", bus4.c_out, 0);
        doneCnt = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (bus4.done) doneCnt++;
            tick();
        end
        checkOutput("abort_no_done", doneCnt, 0);
        applyStimulus(32'h00000005, 32'h00000003, 1'b0);
        waitDone(1'b1, lat, busyCnt);
        checkOutput("after_abort_sum", bus4.sum, 32'h00000008);
        checkOutput("after_abort_latency", lat, 4);
        tick();

        for (int i = 0; i < 1000; i++) begin
            ra    = $urandom;
            rb    = $urandom;
            rc    = 1'($urandom_range(0, 1));
            exp33 = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
            applyStimulus(ra, rb, rc);
            waitDone(1'b1, lat, busyCnt);
            checkOutput("rand4_result", {bus4.c_out, bus4.sum}, exp33);
            tick();
            checkOutput("rand4_pulse", bus4.done, 0);
        end

        for (int i = 0; i < 1000; i++) begin
            ra8  = 8'($urandom);
            rb8  = 8'($urandom);
            rc   = 1'($urandom_range(0, 1));
            exp9 = {1'b0, ra8} + {1'b0, rb8} + {8'd0, rc};
            bus1.a_in  = ra8;
            bus1.b_in  = rb8;
            bus1.c_in  = rc;
            bus1.start = 1'b1;
            tick();
            bus1.start = 1'b0;
            lat = 0;
            while (!bus1.done && lat < 10) begin
                tick();
                lat++;
            end
            checkOutput("rand1_latency", lat, 1);
            checkOutput("rand1_result", {bus1.c_out, bus1.sum}, exp9);
            tick();
            checkOutput("rand1_pulse", bus1.done, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
